// File: rtl/pll_drp_pkg.sv
// -----------------------------------------------------------------------------
// pll_drp_pkg
// Shared definitions for the PLL/MMCM DRP reconfiguration block:
//   - bit positions inside the 64-bit reconfig_to_pll / reconfig_from_pll buses
//   - DRP field widths
//   - FSM state encoding
//   - read-modify-write merge helper
// -----------------------------------------------------------------------------
package pll_drp_pkg;

  localparam int unsigned DRP_ADDR_W = 7;
  localparam int unsigned DRP_DATA_W = 16;

  // reconfig_to_pll layout
  localparam int unsigned TO_DI_LSB    = 0;
  localparam int unsigned TO_DI_MSB    = 15;
  localparam int unsigned TO_DADDR_LSB = 16;
  localparam int unsigned TO_DADDR_MSB = 22;
  localparam int unsigned TO_DEN       = 23;
  localparam int unsigned TO_DWE       = 24;
  localparam int unsigned TO_RST_MMCM  = 25;
  localparam int unsigned TO_DCLK      = 26;

  // reconfig_from_pll layout
  localparam int unsigned FROM_DO_LSB  = 0;
  localparam int unsigned FROM_DO_MSB  = 15;
  localparam int unsigned FROM_DRDY    = 16;
  localparam int unsigned FROM_LOCKED  = 17;

  typedef enum logic [3:0] {
    IDLE,
    RST_ON,
    RD,
    RD_WAIT,
    WR,
    WR_WAIT,
    NEXT,
    RST_OFF,
    LOCK_WAIT
  } state_e;

  // A set mask bit keeps the bit read back from the PLL; a clear bit takes
  // the new value.
  function automatic logic [DRP_DATA_W-1:0] drp_merge(
    input logic [DRP_DATA_W-1:0] rd_val,
    input logic [DRP_DATA_W-1:0] mask,
    input logic [DRP_DATA_W-1:0] data
  );
    return (rd_val & mask) | (data & ~mask);
  endfunction

endpackage

// File: rtl/pll_drp_reconfig_if.sv
// -----------------------------------------------------------------------------
// pll_drp_reconfig_if
// Valid/ready channel that feeds register-update entries to pll_drp_reconfig.
//   cfg_valid : an entry is offered            (master -> slave)
//   cfg_ready : the entry is accepted this cycle (slave -> master)
//   cfg_addr  : DRP register address
//   cfg_data  : new bit values
//   cfg_mask  : 1 = keep the existing bit
//   cfg_last  : final entry of the batch
// -----------------------------------------------------------------------------
interface pll_drp_reconfig_if;

  logic                                   cfg_valid;
  logic                                   cfg_ready;
  logic [pll_drp_pkg::DRP_ADDR_W-1:0]     cfg_addr;
  logic [pll_drp_pkg::DRP_DATA_W-1:0]     cfg_data;
  logic [pll_drp_pkg::DRP_DATA_W-1:0]     cfg_mask;
  logic                                   cfg_last;

  modport master (
    output cfg_valid, cfg_addr, cfg_data, cfg_mask, cfg_last,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_addr, cfg_data, cfg_mask, cfg_last,
    output cfg_ready
  );

endinterface

// File: rtl/pll_drp_timer.sv
// -----------------------------------------------------------------------------
// pll_drp_timer
// Wait-state watchdog: counts enabled cycles and flags the cycle on which the
// LIMIT-th enabled cycle is reached.
//   clk_i     : clock
//   rst_ni    : synchronous active-low reset
//   clear_i   : restart the count from zero
//   en_i      : count this cycle
//   expired_o : this is the LIMIT-th consecutive enabled cycle
// -----------------------------------------------------------------------------
module pll_drp_timer #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired_o = en_i && (count_q == LAST);

endmodule

// File: rtl/pll_drp_reconfig.sv
// -----------------------------------------------------------------------------
// pll_drp_reconfig
// Applies a batch of masked read-modify-write updates to PLL/MMCM DRP
// registers. The PLL is held in reset for the whole batch and released once
// the last write is acknowledged; the batch ends when the PLL relocks.
//
// Ports
//   mgmt_clk          : sole clock, also forwarded as DRP dclk
//   mgmt_reset_n      : synchronous active-low reset
//   cfg               : entry channel (pll_drp_reconfig_if.slave)
//   reconfig_to_pll   : [15:0] di, [22:16] daddr, [23] den, [24] dwe,
//                       [25] rst_mmcm, [26] dclk, [63:27] zero
//   reconfig_from_pll : [15:0] do, [16] drdy, [17] locked, rest ignored
//   busy              : a batch is in progress
//   done              : one-cycle pulse at batch completion
//   err               : sticky timeout flag, cleared at the next batch start
//
// Build option
//   PLL_DRP_TIMEOUT_EN : when defined, DRP waits give up after TIMEOUT_CYCLES
//                        and the relock wait after LOCK_CYCLES, setting err.
//                        When undefined, all waits are unbounded and err is 0.
// -----------------------------------------------------------------------------
module pll_drp_reconfig
  import pll_drp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned LOCK_CYCLES    = 65535
) (
  input  logic                 mgmt_clk,
  input  logic                 mgmt_reset_n,
  pll_drp_reconfig_if.slave    cfg,
  output logic [63:0]          reconfig_to_pll,
  input  logic [63:0]          reconfig_from_pll,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_e                  state_q;
  logic                    ready_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    err_q;
  logic                    den_q;
  logic                    dwe_q;
  logic                    rst_mmcm_q;
  logic [DRP_ADDR_W-1:0]   daddr_q;
  logic [DRP_DATA_W-1:0]   di_q;
  logic [DRP_DATA_W-1:0]   data_q;
  logic [DRP_DATA_W-1:0]   mask_q;
  logic                    last_q;

  logic [DRP_DATA_W-1:0]   di_d;
  logic [DRP_DATA_W-1:0]   drp_do;
  logic                    drdy;
  logic                    locked;
  logic                    handshake;
  logic                    drdy_timeout;
  logic                    lock_timeout;

  assign drp_do    = reconfig_from_pll[FROM_DO_MSB:FROM_DO_LSB];
  assign drdy      = reconfig_from_pll[FROM_DRDY];
  assign locked    = reconfig_from_pll[FROM_LOCKED];
  assign handshake = cfg.cfg_valid && ready_q;
  assign di_d      = drp_merge(drp_do, mask_q, data_q);

  logic unused_from_pll;
  assign unused_from_pll = ^reconfig_from_pll[63:FROM_LOCKED+1];

`ifdef PLL_DRP_TIMEOUT_EN
  logic drdy_wait;
  logic lock_wait;

  assign drdy_wait = (state_q == RD_WAIT) || (state_q == WR_WAIT);
  assign lock_wait = (state_q == LOCK_WAIT);

  pll_drp_timer #(.LIMIT(TIMEOUT_CYCLES)) u_drdy_timer (
    .clk_i     (mgmt_clk),
    .rst_ni    (mgmt_reset_n),
    .clear_i   (!drdy_wait),
    .en_i      (drdy_wait),
    .expired_o (drdy_timeout)
  );

  pll_drp_timer #(.LIMIT(LOCK_CYCLES)) u_lock_timer (
    .clk_i     (mgmt_clk),
    .rst_ni    (mgmt_reset_n),
    .clear_i   (!lock_wait),
    .en_i      (lock_wait),
    .expired_o (lock_timeout)
  );

  assign err = err_q;
`else
  assign drdy_timeout = 1'b0;
  assign lock_timeout = 1'b0;
  assign err          = 1'b0;

  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0) ^ (LOCK_CYCLES == 0) ^ err_q;
`endif

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge mgmt_clk) begin
    if (!mgmt_reset_n) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      den_q      <= 1'b0;
      dwe_q      <= 1'b0;
      rst_mmcm_q <= 1'b0;
      daddr_q    <= '0;
      di_q       <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      last_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (handshake) begin
            daddr_q <= cfg.cfg_addr;
            data_q  <= cfg.cfg_data;
            mask_q  <= cfg.cfg_mask;
            last_q  <= cfg.cfg_last;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            state_q <= RST_ON;
          end
        end
        RST_ON: begin
          // rst_mmcm and the first read strobe become visible together.
          rst_mmcm_q <= 1'b1;
          den_q      <= 1'b1;
          dwe_q      <= 1'b0;
          state_q    <= RD;
        end
        RD: begin
          den_q   <= 1'b0;
          state_q <= RD_WAIT;
        end
        RD_WAIT: begin
          if (drdy) begin
            di_q    <= di_d;
            den_q   <= 1'b1;
            dwe_q   <= 1'b1;
            state_q <= WR;
          end else if (drdy_timeout) begin
            err_q   <= 1'b1;
            state_q <= RST_OFF;
          end
        end
        WR: begin
          den_q   <= 1'b0;
          dwe_q   <= 1'b0;
          state_q <= WR_WAIT;
        end
        WR_WAIT: begin
          if (drdy) begin
            if (last_q) begin
              state_q <= RST_OFF;
            end else begin
              ready_q <= 1'b1;
              state_q <= NEXT;
            end
          end else if (drdy_timeout) begin
            err_q   <= 1'b1;
            state_q <= RST_OFF;
          end
        end
        NEXT: begin
          // PLL stays in reset for as long as the next entry takes to arrive.
          if (handshake) begin
            daddr_q <= cfg.cfg_addr;
            data_q  <= cfg.cfg_data;
            mask_q  <= cfg.cfg_mask;
            last_q  <= cfg.cfg_last;
            ready_q <= 1'b0;
            den_q   <= 1'b1;
            dwe_q   <= 1'b0;
            state_q <= RD;
          end
        end
        RST_OFF: begin
          rst_mmcm_q <= 1'b0;
          state_q    <= LOCK_WAIT;
        end
        LOCK_WAIT: begin
          if (locked || lock_timeout) begin
            err_q   <= err_q | (!locked && lock_timeout);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign busy          = busy_q;
  assign done          = done_q;

  // NOTE: the whole bus gets a default first so no bit can infer a latch.
  always_comb begin
    reconfig_to_pll                            = '0;
    reconfig_to_pll[TO_DI_MSB:TO_DI_LSB]       = di_q;
    reconfig_to_pll[TO_DADDR_MSB:TO_DADDR_LSB] = daddr_q;
    reconfig_to_pll[TO_DEN]                    = den_q;
    reconfig_to_pll[TO_DWE]                    = dwe_q;
    reconfig_to_pll[TO_RST_MMCM]               = rst_mmcm_q;
    reconfig_to_pll[TO_DCLK]                   = mgmt_clk;
  end

endmodule
